auth_sequencial: RTL and testbench

Sequential, parametrised successor to the combinational authentication circuit. Accepts a code as a series of CODE_W-bit symbols (default 3 bits, one A/B/C group per symbol) and compares it against a static secret of DIGITS symbols. Grants access for a fixed hold time and counts failed attempts. Enters a timed lockout once the attempt limit is reached. Sits between the input switch/debounce logic and the indicator/actuator outputs.

---
 rtl/auth_sequencial_pkg.sv | 16 +
 rtl/auth_timer.sv | 38 +++
 rtl/auth_sequencial.sv | 146 ++++++++++++++
 tb/tb_auth_sequencial.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/auth_sequencial_pkg.sv
// Shared types and helpers for the sequential authentication block.
package auth_sequencial_pkg;

    typedef enum logic [2:0] {
        ST_COLLECT = 3'd0,
        ST_CHECK   = 3'd1,
        ST_GRANT   = 3'd2,
        ST_DENY    = 3'd3,
        ST_LOCK    = 3'd4
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/auth_timer.sv
// Loadable down-counter shared by the grant-hold and lockout phases.
// Saturates at zero so it can never underflow.
module auth_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/auth_sequencial.sv
// Sequential code-lock: collects DIGITS symbols, compares them against a static
// secret, then grants, denies or locks out based on the remaining attempt budget.
module auth_sequencial
    import auth_sequencial_pkg::*;
#(
    parameter int CODE_W      = 3,
    parameter int DIGITS      = 4,
    parameter int MAX_TRIES   = 3,
    parameter int HOLD_CYCLES = 8,
    parameter int LOCK_CYCLES = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [CODE_W-1:0]              sym_in,
    input  logic                           sym_valid,
    input  logic                           clear,
    input  logic [DIGITS*CODE_W-1:0]       secret,
    output logic                           granted,
    output logic                           denied,
    output logic                           locked,
    output logic [$clog2(DIGITS+1)-1:0]    digit_cnt,
    output logic [$clog2(MAX_TRIES+1)-1:0] tries_left
);

    localparam int CNT_W = $clog2(DIGITS + 1);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam int TMR_W = max_int($clog2(max_int(HOLD_CYCLES, LOCK_CYCLES)), 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   digit_cnt_q, digit_cnt_d;
    logic               flag_q, flag_d;
    logic [TRY_W-1:0]   tries_q, tries_d;
    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_load_val;
    logic [TMR_W-1:0]   tmr_cnt;
    logic               tmr_zero;
    logic [CODE_W-1:0]  exp_sym;

    // Mux over legal digit indices only, so no slice can ever fall outside secret.
    always_comb begin
        exp_sym = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_cnt_q == CNT_W'(i)) begin
                exp_sym = secret[i*CODE_W +: CODE_W];
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can infer a latch.
    always_comb begin
        state_d      = state_q;
        digit_cnt_d  = digit_cnt_q;
        flag_d       = flag_q;
        tries_d      = tries_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;

        case (state_q)
            ST_COLLECT: begin
                if (clear) begin
                    digit_cnt_d = '0;
                    flag_d      = 1'b0;
                end else if (sym_valid) begin
                    flag_d      = flag_q | (sym_in != exp_sym);
                    digit_cnt_d = digit_cnt_q + CNT_W'(1);
                    if (digit_cnt_q == CNT_W'(DIGITS - 1)) begin
                        state_d = ST_CHECK;
                    end
                end
            end

            ST_CHECK: begin
                digit_cnt_d = '0;
                flag_d      = 1'b0;
                if (!flag_q) begin
                    state_d      = ST_GRANT;
                    tries_d      = TRY_W'(MAX_TRIES);
                    tmr_load     = 1'b1;
                    tmr_load_val = TMR_W'(HOLD_CYCLES - 1);
                end else if (tries_q > TRY_W'(1)) begin
                    state_d = ST_DENY;
                    tries_d = tries_q - TRY_W'(1);
                end else begin
                    state_d      = ST_LOCK;
                    tries_d      = '0;
                    tmr_load     = 1'b1;
                    tmr_load_val = TMR_W'(LOCK_CYCLES - 1);
                end
            end

            ST_GRANT: begin
                if (clear || tmr_zero) begin
                    state_d = ST_COLLECT;
                end
            end

            ST_DENY: begin
                state_d = ST_COLLECT;
            end

            ST_LOCK: begin
                if (tmr_zero) begin
                    state_d = ST_COLLECT;
                    tries_d = TRY_W'(MAX_TRIES);
                end
            end

            default: begin
                state_d = ST_COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_COLLECT;
            digit_cnt_q <= '0;
            flag_q      <= 1'b0;
            tries_q     <= TRY_W'(MAX_TRIES);
        end else begin
            state_q     <= state_d;
            digit_cnt_q <= digit_cnt_d;
            flag_q      <= flag_d;
            tries_q     <= tries_d;
        end
    end

    auth_timer #(
        .W(TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .cnt      (tmr_cnt),
        .zero     (tmr_zero)
    );

    assign granted    = (state_q == ST_GRANT);
    assign denied     = (state_q == ST_DENY);
    assign locked     = (state_q == ST_LOCK);
    assign digit_cnt  = digit_cnt_q;
    assign tries_left = tries_q;

endmodule

// File: tb/tb_auth_sequencial.sv
// Directed bench for auth_sequencial with secret digits 1,7,2,5 in entry order.
module tb_auth_sequencial;

    logic        clk;
    logic        rst_n;
    logic [2:0]  sym_in;
    logic        sym_valid;
    logic        clear;
    logic [11:0] secret;
    logic        granted;
    logic        denied;
    logic        locked;
    logic [2:0]  digit_cnt;
    logic [1:0]  tries_left;

    int n_checks = 0;
    int n_pass   = 0;

    auth_sequencial #(
        .CODE_W      (3),
        .DIGITS      (4),
        .MAX_TRIES   (3),
        .HOLD_CYCLES (8),
        .LOCK_CYCLES (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sym_in     (sym_in),
        .sym_valid  (sym_valid),
        .clear      (clear),
        .secret     (secret),
        .granted    (granted),
        .denied     (denied),
        .locked     (locked),
        .digit_cnt  (digit_cnt),
        .tries_left (tries_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic strobe(input logic [2:0] s);
        sym_in    = s;
        sym_valid = 1'b1;
        step();
        sym_valid = 1'b0;
    endtask

    task automatic enter(input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] c, input logic [2:0] d);
        strobe(a);
        strobe(b);
        strobe(c);
        strobe(d);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_granted"}, granted, 0);
        check({tag, "_denied"},  denied,  0);
        check({tag, "_locked"},  locked,  0);
    endtask

    int gcnt;
    int lcnt;
    int bad_excl;

    initial begin
        secret    = {3'd5, 3'd2, 3'd7, 3'd1};
        sym_in    = '0;
        sym_valid = 1'b0;
        clear     = 1'b0;
        rst_n     = 1'b0;
        step();
        rst_n = 1'b1;

        // Reset state
        check_idle_outputs("rst");
        check("rst_digit_cnt", digit_cnt, 0);
        check("rst_tries", tries_left, 3);

        // Correct entry: CHECK after 4th strobe, grant on the following edge for 8 cycles
        enter(1, 7, 2, 5);
        check("ok_check_cnt", digit_cnt, 4);
        check("ok_check_granted", granted, 0);
        step();
        check("ok_granted", granted, 1);
        check("ok_tries", tries_left, 3);
        gcnt     = 1;
        bad_excl = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (granted) gcnt++;
            if (denied || locked) bad_excl++;
        end
        check("ok_grant_len", gcnt, 8);
        check("ok_no_deny_lock", bad_excl, 0);

        // Single wrong attempt, then a correct one restores the budget
        enter(1, 7, 2, 6);
        step();
        check("wrong_denied", denied, 1);
        check("wrong_granted", granted, 0);
        check("wrong_tries", tries_left, 2);
        step();
        check("wrong_deny_len", denied, 0);
        enter(1, 7, 2, 5);
        step();
        check("retry_granted", granted, 1);
        check("retry_tries", tries_left, 3);
        idle(8);
        check("retry_grant_end", granted, 0);

        // Lockout after three wrong entries
        enter(0, 0, 0, 0);
        step();
        check("lk1_denied", denied, 1);
        check("lk1_tries", tries_left, 2);
        step();
        enter(0, 0, 0, 0);
        step();
        check("lk2_denied", denied, 1);
        check("lk2_tries", tries_left, 1);
        step();
        enter(0, 0, 0, 0);
        step();
        check("lk3_locked", locked, 1);
        check("lk3_denied", denied, 0);
        check("lk3_tries", tries_left, 0);
        lcnt     = 1;
        bad_excl = 0;
        for (int i = 0; i < 15; i++) begin
            sym_in    = 3'd1;
            sym_valid = 1'b1;
            clear     = (i == 3);
            step();
            if (locked) lcnt++;
            if (granted || denied || digit_cnt != 0) bad_excl++;
        end
        sym_valid = 1'b0;
        clear     = 1'b0;
        check("lk_ignore_inputs", bad_excl, 0);
        step();
        check("lk_len", lcnt, 16);
        check("lk_end_locked", locked, 0);
        check("lk_end_tries", tries_left, 3);
        check("lk_end_cnt", digit_cnt, 0);
        enter(1, 7, 2, 5);
        step();
        check("lk_after_granted", granted, 1);
        idle(8);

        // clear wins over a simultaneous strobe and also discards the mismatch flag
        strobe(1);
        strobe(0);
        sym_in    = 3'd2;
        sym_valid = 1'b1;
        clear     = 1'b1;
        step();
        sym_valid = 1'b0;
        clear     = 1'b0;
        check("clr_cnt", digit_cnt, 0);
        check("clr_tries", tries_left, 3);
        enter(1, 7, 2, 5);
        step();
        check("clr_then_granted", granted, 1);
        step();
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_grant_drop", granted, 0);
        check("clr_grant_cnt", digit_cnt, 0);
        check("clr_grant_tries", tries_left, 3);

        // Reset in the middle of an entry, with one attempt already spent
        enter(0, 0, 0, 0);
        step();
        step();
        check("rst_pre_tries", tries_left, 2);
        strobe(1);
        strobe(7);
        strobe(2);
        sym_in    = 3'd5;
        sym_valid = 1'b1;
        rst_n     = 1'b0;
        step();
        rst_n     = 1'b1;
        sym_valid = 1'b0;
        check("rst_mid_cnt", digit_cnt, 0);
        check("rst_mid_tries", tries_left, 3);
        check_idle_outputs("rst_mid");
        step();
        check("rst_mid_no_grant", granted, 0);
        check("rst_mid_cnt2", digit_cnt, 0);

        // Reset during lockout
        for (int k = 0; k < 3; k++) begin
            enter(0, 0, 0, 0);
            step();
            if (k < 2) step();
        end
        idle(3);
        check("rst_lk_locked", locked, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_idle_outputs("rst_lk");
        check("rst_lk_tries", tries_left, 3);
        check("rst_lk_cnt", digit_cnt, 0);
        enter(1, 7, 2, 5);
        step();
        check("rst_lk_granted", granted, 1);
        idle(8);

        // Strobes during CHECK, DENY and GRANT are ignored; first one back in COLLECT is digit 0
        enter(1, 7, 2, 6);
        sym_in    = 3'd1;
        sym_valid = 1'b1;
        step();
        check("bp_deny", denied, 1);
        check("bp_check_cnt", digit_cnt, 0);
        step();
        check("bp_deny_cnt", digit_cnt, 0);
        check("bp_deny_end", denied, 0);
        step();
        check("bp_first_cnt", digit_cnt, 1);
        sym_valid = 1'b0;
        enter(7, 2, 5, 0);
        check("bp_extra_cnt", digit_cnt, 0);
        check("bp_granted", granted, 1);
        check("bp_tries", tries_left, 3);
        bad_excl = 0;
        sym_in    = 3'd1;
        sym_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            if (digit_cnt != 0 || !granted) bad_excl++;
        end
        sym_valid = 1'b0;
        check("bp_grant_ignore", bad_excl, 0);
        step();
        check("bp_grant_end", granted, 0);
        check("bp_end_cnt", digit_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
